// File: rtl/spi_eeprom_pkg.sv
// Shared types and constants for the SPI EEPROM read scheduler.
package spi_eeprom_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_START  = 2'd1,
        ST_STREAM = 2'd2,
        ST_GAP    = 2'd3
    } sched_state_e;

    localparam int ADDR_W_DEF = 24;

    // READ command byte issued by the serial reader when it sees OUT_memRead.
    localparam logic [7:0] EEPROM_READ_OP = 8'h03;

    // Width needed to hold an index/count below n, never less than one bit.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_eeprom_sched_rr_arbiter.sv
// Round-robin arbiter: first set request at or after ptr_i, wrapping.
// Purely combinational; the caller owns and updates the pointer.
module rr_arbiter
    import spi_eeprom_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    localparam int ID_W    = clog2_min1(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] grant_oh_o,
    output logic [ID_W-1:0]    grant_idx_o,
    output logic               grant_vld_o
);

    logic found;

    // Two passes: upper window [ptr, N) first, then wrap to [0, N).
    always_comb begin
        grant_oh_o  = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_i[i] && (ID_W'(i) >= ptr_i)) begin
                found          = 1'b1;
                grant_oh_o[i]  = 1'b1;
                grant_idx_o    = ID_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_i[i]) begin
                found          = 1'b1;
                grant_oh_o[i]  = 1'b1;
                grant_idx_o    = ID_W'(i);
            end
        end
        grant_vld_o = found;
    end

endmodule

// File: rtl/spi_eeprom_sched.sv
// Shares one bit-serial SPI EEPROM reader among NUM_REQ requesters.
//
//   state     | meaning
//   ----------+-----------------------------------------------------
//   ST_IDLE   | waiting for a request; grants one round-robin
//   ST_START  | ack visible; issue the one-cycle read start next
//   ST_STREAM | packing serial bits into bytes until LEN+1 emitted
//   ST_GAP    | cancel issued; hold CS idle for GAP_CYC cycles
module spi_eeprom_sched
    import spi_eeprom_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    parameter  int ADDR_W  = ADDR_W_DEF,
    parameter  int LEN_W   = 8,
    parameter  int GAP_CYC = 2,
    localparam int ID_W    = clog2_min1(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        IN_req,
    input  logic [NUM_REQ*ADDR_W-1:0] IN_reqAddr,
    input  logic [NUM_REQ*LEN_W-1:0]  IN_reqLen,
    output logic [NUM_REQ-1:0]        OUT_reqAck,
    output logic [7:0]                OUT_data,
    output logic                      OUT_dataValid,
    output logic [ID_W-1:0]           OUT_dataId,
    output logic                      OUT_done,
    output logic                      OUT_busy,
    output logic [ADDR_W-1:0]         OUT_memAddr,
    output logic                      OUT_memRead,
    output logic                      OUT_memCancel,
    input  logic                      IN_memData,
    input  logic                      IN_memDataValid,
    input  logic                      IN_memDataByte
);

    localparam int GAP_W = clog2_min1(GAP_CYC + 1);

    sched_state_e        state_q;
    logic [ID_W-1:0]     ptr_q;
    logic [ID_W-1:0]     id_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [LEN_W-1:0]    byte_cnt_q;
    logic [GAP_W-1:0]    gap_cnt_q;
    logic [6:0]          sr_q;
    logic [7:0]          data_q;
    logic                dvalid_q;
    logic                done_q;
    logic                read_q;
    logic                cancel_q;
    logic [NUM_REQ-1:0]  ack_q;

    logic [NUM_REQ-1:0]  grant_oh;
    logic [ID_W-1:0]     grant_idx;
    logic                grant_vld;
    logic [ID_W-1:0]     ptr_d;
    logic [ADDR_W-1:0]   sel_addr_d;
    logic [LEN_W-1:0]    sel_len_d;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req_i       (IN_req),
        .ptr_i       (ptr_q),
        .grant_oh_o  (grant_oh),
        .grant_idx_o (grant_idx),
        .grant_vld_o (grant_vld)
    );

    // Pick the granted requester's address/length slice and the next RR pointer.
    always_comb begin
        sel_addr_d = '0;
        sel_len_d  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_oh[i]) begin
                sel_addr_d = IN_reqAddr[i*ADDR_W +: ADDR_W];
                sel_len_d  = IN_reqLen[i*LEN_W +: LEN_W];
            end
        end
        ptr_d = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
    end

    // Scheduler FSM with byte shifter, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            id_q       <= '0;
            addr_q     <= '0;
            byte_cnt_q <= '0;
            gap_cnt_q  <= '0;
            sr_q       <= '0;
            data_q     <= '0;
            dvalid_q   <= 1'b0;
            done_q     <= 1'b0;
            read_q     <= 1'b0;
            cancel_q   <= 1'b0;
            ack_q      <= '0;
        end else begin
            ack_q    <= '0;
            read_q   <= 1'b0;
            cancel_q <= 1'b0;
            dvalid_q <= 1'b0;
            done_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (grant_vld) begin
                        ack_q      <= grant_oh;
                        addr_q     <= sel_addr_d;
                        byte_cnt_q <= sel_len_d;
                        id_q       <= grant_idx;
                        ptr_q      <= ptr_d;
                        sr_q       <= '0;
                        state_q    <= ST_START;
                    end
                end
                ST_START: begin
                    read_q  <= 1'b1;
                    state_q <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (IN_memDataValid) begin
                        sr_q <= {sr_q[5:0], IN_memData};
                        if (IN_memDataByte) begin
                            data_q   <= {sr_q, IN_memData};
                            dvalid_q <= 1'b1;
                            // Last byte: stop the counter at zero rather than wrap.
                            if (byte_cnt_q == '0) begin
                                done_q    <= 1'b1;
                                cancel_q  <= 1'b1;
                                gap_cnt_q <= GAP_W'(GAP_CYC);
                                state_q   <= ST_GAP;
                            end else begin
                                byte_cnt_q <= byte_cnt_q - LEN_W'(1);
                            end
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q <= GAP_W'(1)) begin
                        gap_cnt_q <= '0;
                        state_q   <= ST_IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - GAP_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign OUT_reqAck    = ack_q;
    assign OUT_data      = data_q;
    assign OUT_dataValid = dvalid_q;
    assign OUT_dataId    = id_q;
    assign OUT_done      = done_q;
    assign OUT_busy      = (state_q != ST_IDLE);
    assign OUT_memAddr   = addr_q;
    assign OUT_memRead   = read_q;
    assign OUT_memCancel = cancel_q;

endmodule
